// File: rtl/mips_pkg.sv
// Shared writeback definitions: register-file geometry and the queued-result entry
// used by the MDU result FIFO.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic              killed;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // An entry still owes a register-file write only if it is valid and not superseded.
  function automatic logic entry_live(input wb_entry_t e);
    return e.valid & ~e.killed;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous MDU result FIFO with per-entry killed bits, a kill-by-address port
// and two address-match query ports for the pending-write scoreboard.
module wb_fifo #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [ADDR_W-1:0]        i_push_addr,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  input  logic                     i_kill,
  input  logic [ADDR_W-1:0]        i_kill_addr,
  input  logic [ADDR_W-1:0]        i_q_addr1,
  input  logic [ADDR_W-1:0]        i_q_addr2,
  output logic                     o_match1,
  output logic                     o_match2,
  output logic                     o_head_killed,
  output logic [ADDR_W-1:0]        o_head_addr,
  output logic [DATA_W-1:0]        o_head_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  import mips_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_match1;
  logic             w_match2;

  // Caller gates push/pop; these guards keep pointers sane regardless.
  assign w_push = i_push & (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_pop & (r_count != CNT_W'(0));

  // Entry storage, kill marking and pointer/occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= PTR_W'(0);
      r_wr_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && r_mem[i].valid && (r_mem[i].addr == i_kill_addr)) begin
          r_mem[i].killed <= 1'b1;
        end
      end
      if (w_pop) begin
        r_mem[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr              <= r_rd_ptr + PTR_W'(1);
      end
      // A same-cycle push is younger than the killing write, so it lands unkilled.
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{valid: 1'b1, killed: 1'b0, addr: i_push_addr, data: i_push_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Address match against every entry that still owes a write.
  always_comb begin
    w_match1 = 1'b0;
    w_match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match1 = w_match1 | (entry_live(r_mem[i]) & (r_mem[i].addr == i_q_addr1));
      w_match2 = w_match2 | (entry_live(r_mem[i]) & (r_mem[i].addr == i_q_addr2));
    end
  end

  assign o_match1      = w_match1;
  assign o_match2      = w_match2;
  assign o_head_killed = r_mem[r_rd_ptr].killed;
  assign o_head_addr   = r_mem[r_rd_ptr].addr;
  assign o_head_data   = r_mem[r_rd_ptr].data;
  assign o_count       = r_count;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Writeback-stage arbiter: merges ALU results (priority) and queued MDU results onto
// the single register-file write port, with a starvation guard and RAW scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int ADDR_W     = mips_pkg::ADDR_W,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_alu_valid,
  input  logic [ADDR_W-1:0]      i_alu_addr,
  input  logic [DATA_W-1:0]      i_alu_data,
  output logic                   o_alu_stall,
  input  logic                   i_mdu_valid,
  output logic                   o_mdu_ready,
  input  logic [ADDR_W-1:0]      i_mdu_addr,
  input  logic [DATA_W-1:0]      i_mdu_data,
  output logic                   o_rf_we,
  output logic [ADDR_W-1:0]      o_rf_waddr,
  output logic [DATA_W-1:0]      o_rf_wdata,
  input  logic [ADDR_W-1:0]      i_q_addr1,
  input  logic [ADDR_W-1:0]      i_q_addr2,
  output logic                   o_pend_hit1,
  output logic                   o_pend_hit2,
  output logic [$clog2(DEPTH):0] o_fifo_count
);
  import mips_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX) + 1;

  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_alu_wr;
  logic              w_head_killed;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_match1;
  logic              w_match2;
  logic              w_nx_we;
  logic [ADDR_W-1:0] w_nx_waddr;
  logic [DATA_W-1:0] w_nx_wdata;

  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_stall;
  logic [STV_W-1:0]  r_starve;

  assign w_empty     = (w_count == CNT_W'(0));
  assign w_full      = (w_count == CNT_W'(DEPTH));
  assign o_mdu_ready = ~rst & ~w_full;
  // Writes to r0 are accepted but never allocate an entry.
  assign w_push      = i_mdu_valid & o_mdu_ready & (i_mdu_addr != REG_ZERO);
  assign w_alu_wr    = ~r_stall & i_alu_valid & (i_alu_addr != REG_ZERO);
  assign w_pop       = ~w_empty & ~w_alu_wr;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_push_addr   (i_mdu_addr),
    .i_push_data   (i_mdu_data),
    .i_pop         (w_pop),
    .i_kill        (w_alu_wr),
    .i_kill_addr   (i_alu_addr),
    .i_q_addr1     (i_q_addr1),
    .i_q_addr2     (i_q_addr2),
    .o_match1      (w_match1),
    .o_match2      (w_match2),
    .o_head_killed (w_head_killed),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_count       (w_count)
  );

  // Source selection for the next register-file write.
  always_comb begin
    w_nx_we    = 1'b0;
    w_nx_waddr = ADDR_W'(0);
    w_nx_wdata = DATA_W'(0);
    if (w_alu_wr) begin
      w_nx_we    = 1'b1;
      w_nx_waddr = i_alu_addr;
      w_nx_wdata = i_alu_data;
    end else if (w_pop && !w_head_killed) begin
      w_nx_we    = 1'b1;
      w_nx_waddr = w_head_addr;
      w_nx_wdata = w_head_data;
    end else begin
      w_nx_we    = 1'b0;
      w_nx_waddr = ADDR_W'(0);
      w_nx_wdata = DATA_W'(0);
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= ADDR_W'(0);
      r_rf_wdata <= DATA_W'(0);
    end else begin
      r_rf_we    <= w_nx_we;
      r_rf_waddr <= w_nx_waddr;
      r_rf_wdata <= w_nx_wdata;
    end
  end

  // Starvation guard: the stall lands in the cycle the counter would show STARVE_MAX-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= STV_W'(0);
      r_stall  <= 1'b0;
    end else if (w_empty || w_pop) begin
      r_starve <= STV_W'(0);
      r_stall  <= 1'b0;
    end else begin
      r_starve <= r_starve + STV_W'(1);
      r_stall  <= (r_starve == STV_W'(STARVE_MAX - 2));
    end
  end

  assign o_pend_hit1  = (i_q_addr1 != REG_ZERO) &
                        (w_match1 | (r_rf_we & (r_rf_waddr == i_q_addr1)));
  assign o_pend_hit2  = (i_q_addr2 != REG_ZERO) &
                        (w_match2 | (r_rf_we & (r_rf_waddr == i_q_addr2)));
  assign o_alu_stall  = r_stall;
  assign o_rf_we      = r_rf_we;
  assign o_rf_waddr   = r_rf_waddr;
  assign o_rf_wdata   = r_rf_wdata;
  assign o_fifo_count = w_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter plus hand-written
// starvation and mid-operation reset sequences.
module tb_regfile_write_arbiter;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_stall;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
    logic [2:0]  e_cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic [2:0]  fifo_count;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl [28];

  regfile_write_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .DEPTH      (4),
    .STARVE_MAX (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_alu_valid  (alu_valid),
    .i_alu_addr   (alu_addr),
    .i_alu_data   (alu_data),
    .o_alu_stall  (alu_stall),
    .i_mdu_valid  (mdu_valid),
    .o_mdu_ready  (mdu_ready),
    .i_mdu_addr   (mdu_addr),
    .i_mdu_data   (mdu_data),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .i_q_addr1    (q_addr1),
    .i_q_addr2    (q_addr2),
    .o_pend_hit1  (pend_hit1),
    .o_pend_hit2  (pend_hit2),
    .o_fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic apply(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] q1, input logic [4:0] q2);
    @(posedge clk);
    #1;
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md; q_addr1 = q1; q_addr2 = q2;
    @(negedge clk);
    n_vec++;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    chk({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, we});
    if (we) begin
      chk({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, wa});
      chk({tag, " rf_wdata"}, rf_wdata, wd);
    end
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0; q_addr1 = 5'd0; q_addr2 = 5'd0;

    //            av    aa     ad            mv    ma     md          q1     q2     we    wa     wd            st    rdy   h1    h2    cnt
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 5'd5,  32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,      5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd5,  5'd0,  1'b1, 5'd5,  32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 5'd20, 32'h14,       1'b1, 5'd8,  32'h80,     5'd8,  5'd20, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 5'd20, 32'h15,       1'b1, 5'd9,  32'h90,     5'd8,  5'd20, 1'b1, 5'd20, 32'h14,       1'b0, 1'b1, 1'b1, 1'b1, 3'd1};
    tbl[5]  = '{1'b1, 5'd20, 32'h16,       1'b1, 5'd10, 32'hA0,     5'd8,  5'd20, 1'b1, 5'd20, 32'h15,       1'b0, 1'b1, 1'b1, 1'b1, 3'd2};
    tbl[6]  = '{1'b1, 5'd20, 32'h17,       1'b1, 5'd11, 32'hB0,     5'd8,  5'd20, 1'b1, 5'd20, 32'h16,       1'b0, 1'b1, 1'b1, 1'b1, 3'd3};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0,     5'd11, 5'd12, 1'b1, 5'd20, 32'h17,       1'b0, 1'b0, 1'b1, 1'b0, 3'd4};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd8,  5'd9,  1'b1, 5'd8,  32'h80,       1'b0, 1'b1, 1'b1, 1'b1, 3'd3};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd11, 5'd0,  1'b1, 5'd9,  32'h90,       1'b0, 1'b1, 1'b1, 1'b0, 3'd2};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd11, 5'd0,  1'b1, 5'd10, 32'hA0,       1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd11, 5'd0,  1'b1, 5'd11, 32'hB0,       1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd11, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h11,     5'd3,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[14] = '{1'b1, 5'd3,  32'h22,       1'b0, 5'd0,  32'h0,      5'd3,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd3,  5'd0,  1'b1, 5'd3,  32'h22,       1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd3,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[17] = '{1'b1, 5'd0,  32'hDEAD,     1'b1, 5'd0,  32'hBEEF,   5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[18] = '{1'b1, 5'd0,  32'hDEAD,     1'b1, 5'd0,  32'hBEEF,   5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[19] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[20] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77,     5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[21] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,      5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[22] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd7,  5'd0,  1'b1, 5'd7,  32'h77,       1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[23] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[24] = '{1'b1, 5'd6,  32'h66,       1'b1, 5'd6,  32'h60,     5'd6,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[25] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd6,  5'd0,  1'b1, 5'd6,  32'h66,       1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[26] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd6,  5'd0,  1'b1, 5'd6,  32'h60,       1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    tbl[27] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      5'd6,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

    // Reset state, including zeroed write address/data and mdu_ready held low.
    apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset alu_stall", {31'd0, alu_stall}, 32'd0);
    chk("reset mdu_ready", {31'd0, mdu_ready}, 32'd0);
    chk("reset fifo_count", {29'd0, fifo_count}, 32'd0);

    for (int i = 0; i < 28; i++) begin
      apply(1'b0, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].q1, tbl[i].q2);
      chk_rf($sformatf("T%0d", i), tbl[i].e_we, tbl[i].e_wa, tbl[i].e_wd);
      chk($sformatf("T%0d alu_stall", i), {31'd0, alu_stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("T%0d mdu_ready", i), {31'd0, mdu_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("T%0d pend_hit1", i), {31'd0, pend_hit1}, {31'd0, tbl[i].e_h1});
      chk($sformatf("T%0d pend_hit2", i), {31'd0, pend_hit2}, {31'd0, tbl[i].e_h2});
      chk($sformatf("T%0d fifo_count", i), {29'd0, fifo_count}, {29'd0, tbl[i].e_cnt});
    end

    // Starvation: one queued MDU entry behind back-to-back ALU writes to r21.
    // The stall lands 8 cycles after the push; the ALU op held during it is data 108.
    for (int k = 0; k <= 10; k++) begin
      apply(1'b0, (k <= 9), (k <= 9) ? 5'd21 : 5'd0, (k <= 8) ? 32'd100 + 32'(k) : 32'd108,
            (k == 0), (k == 0) ? 5'd13 : 5'd0, 32'hD0, 5'd13, 5'd21);
      chk($sformatf("S%0d alu_stall", k), {31'd0, alu_stall}, {31'd0, (k == 8)});
      chk($sformatf("S%0d fifo_count", k), {29'd0, fifo_count}, ((k >= 1) && (k <= 8)) ? 32'd1 : 32'd0);
      if (k == 0) begin
        chk_rf("S0", 1'b0, 5'd0, 32'h0);
      end else if (k <= 8) begin
        chk_rf($sformatf("S%0d", k), 1'b1, 5'd21, 32'd100 + 32'(k - 1));
      end else if (k == 9) begin
        chk_rf("S9", 1'b1, 5'd13, 32'hD0);
      end else begin
        chk_rf("S10", 1'b1, 5'd21, 32'd108);
      end
    end

    // Reset with three queued MDU results: nothing stale may reach the register file.
    apply(1'b0, 1'b1, 5'd22, 32'h1, 1'b1, 5'd14, 32'hE0, 5'd0, 5'd0);
    apply(1'b0, 1'b1, 5'd22, 32'h2, 1'b1, 5'd15, 32'hE1, 5'd0, 5'd0);
    apply(1'b0, 1'b1, 5'd22, 32'h3, 1'b1, 5'd16, 32'hE2, 5'd0, 5'd0);
    apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd14, 5'd0);
    chk("R3 fifo_count", {29'd0, fifo_count}, 32'd3);
    chk("R3 mdu_ready", {31'd0, mdu_ready}, 32'd0);
    chk_rf("R3", 1'b1, 5'd22, 32'h3);
    apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd14, 5'd16);
    chk("R4 fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("R4 rf_we", {31'd0, rf_we}, 32'd0);
    chk("R4 rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("R4 rf_wdata", rf_wdata, 32'd0);
    chk("R4 mdu_ready", {31'd0, mdu_ready}, 32'd1);
    chk("R4 pend_hit1", {31'd0, pend_hit1}, 32'd0);
    chk("R4 pend_hit2", {31'd0, pend_hit2}, 32'd0);
    for (int k = 5; k <= 7; k++) begin
      apply(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd15, 5'd0);
      chk($sformatf("R%0d rf_we", k), {31'd0, rf_we}, 32'd0);
      chk($sformatf("R%0d fifo_count", k), {29'd0, fifo_count}, 32'd0);
      chk($sformatf("R%0d pend_hit1", k), {31'd0, pend_hit1}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
